// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Descriptor-driven controller for the digit-detector datapath. A small
//   table of layer descriptors is walked in order; each layer expands into
//   one or more engine passes. Each pass gets exactly one eng_start pulse
//   together with its RAM base addresses.
//
//   Ports
//     clk, rst          clock, asynchronous active-high reset
//     GO                start pulse, accepted only in IDLE
//     desc_we/addr/data descriptor table write port, ignored while busy
//     eng_op            engine select: 0 conv, 1 maxp, 2 dense, 3 result
//     eng_start         one-cycle start pulse for the current pass
//     eng_done          STOP pulse from the engine, honoured only in WAIT
//     memstartp/w/zap   read / weight / write base addresses of the pass
//     matrix, bias,     feature-map side, last-input-group flag and
//     globmaxp_en       global max-pool write mode of the pass
//     res_in            class index from the result engine
//     RESULT            detected digit, 4'b1111 while STOP=0
//     STOP, busy, err   finished, running, table overrun (sticky to next GO)
//
//   Optional feature macro: LAYER_SEQ_PERF_EN adds perf_cycles and
//   perf_total counters and ports.
//
//   Timing: GO in cycle 1 moves to FETCH; FETCH in cycle 2 latches the
//   descriptor; ISSUE in cycle 3 raises eng_start. Pass outputs are valid in
//   ISSUE and WAIT only and read 0 in every other state.
//
//   Handshake: the engine owns its pass between eng_start and eng_done;
//   eng_done is consumed only in WAIT, so a stray or late eng_done in any
//   other state has no effect.
module layer_sequencer #(
  parameter int NUM_LAYERS       = 16,
  parameter int SIZE_address_pix = 13,
  parameter int SIZE_address_wei = 13,
  parameter int DESC_W           = 56,
  localparam int LW = $clog2(NUM_LAYERS),
  localparam int PW = SIZE_address_pix,
  localparam int WW = SIZE_address_wei
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              GO,
  input  logic              desc_we,
  input  logic [LW-1:0]     desc_addr,
  input  logic [DESC_W-1:0] desc_data,
  output logic [1:0]        eng_op,
  output logic              eng_start,
  input  logic              eng_done,
  output logic [PW-1:0]     memstartp,
  output logic [WW-1:0]     memstartw,
  output logic [PW-1:0]     memstartzap,
  output logic [4:0]        matrix,
  output logic              bias,
  output logic              globmaxp_en,
  input  logic [3:0]        res_in,
  output logic [3:0]        RESULT,
  output logic              STOP,
  output logic              busy,
  output logic              err
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_total
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_ADV, S_DONE
  } state_t;

  localparam logic [1:0] OP_CONV = 2'd0;
  localparam logic [1:0] OP_MAXP = 2'd1;
  localparam logic [1:0] OP_RES  = 2'd3;

  // Table has no reset so its contents survive rst.
  logic [DESC_W-1:0] table_q [NUM_LAYERS];

  state_t            state_q, state_d;
  logic [LW-1:0]     layer_q, layer_d;
  logic [3:0]        oc_q, oc_d;
  logic [3:0]        ig_q, ig_d;
  logic [DESC_W-1:0] desc_q, desc_d;
  logic [3:0]        result_q, result_d;
  logic              stop_q, stop_d;
  logic              err_q, err_d;
  logic              layer_end;

  // Descriptor fields
  logic [1:0]  d_op;
  logic        d_last, d_gmp;
  logic [4:0]  d_mat;
  logic [3:0]  d_igmax, d_ocmax;
  logic [12:0] d_src, d_dst, d_wbase;
  logic [9:0]  m2;
  logic        pass_valid;

  assign d_op    = desc_q[55:54];
  assign d_last  = desc_q[53];
  assign d_gmp   = desc_q[52];
  assign d_mat   = desc_q[51:47];
  assign d_igmax = desc_q[46:43];
  assign d_ocmax = desc_q[42:39];
  assign d_src   = desc_q[38:26];
  assign d_dst   = desc_q[25:13];
  assign d_wbase = desc_q[12:0];
  assign m2      = 10'(d_mat) * 10'(d_mat);

  always_ff @(posedge clk) begin
    if (desc_we && !busy) table_q[desc_addr] <= desc_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      layer_q  <= '0;
      oc_q     <= '0;
      ig_q     <= '0;
      desc_q   <= '0;
      result_q <= 4'hF;
      stop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      oc_q     <= oc_d;
      ig_q     <= ig_d;
      desc_q   <= desc_d;
      result_q <= result_d;
      stop_q   <= stop_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    oc_d      = oc_q;
    ig_d      = ig_q;
    desc_d    = desc_q;
    result_d  = result_q;
    stop_d    = stop_q;
    err_d     = err_q;
    layer_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (GO) begin
          state_d  = S_FETCH;
          stop_d   = 1'b0;
          err_d    = 1'b0;
          layer_d  = '0;
          oc_d     = '0;
          ig_d     = '0;
          result_d = 4'hF;
        end
      end
      S_FETCH: begin
        desc_d  = table_q[layer_q];
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          state_d = S_ADV;
          if (d_op == OP_RES) result_d = res_in;
        end
      end
      S_ADV: begin
        layer_end = 1'b1;
        // ig is the innermost loop for conv; maxp walks oc only.
        case (d_op)
          OP_CONV: begin
            if (ig_q != d_igmax) begin
              ig_d      = ig_q + 4'd1;
              layer_end = 1'b0;
            end else if (oc_q != d_ocmax) begin
              ig_d      = '0;
              oc_d      = oc_q + 4'd1;
              layer_end = 1'b0;
            end
          end
          OP_MAXP: begin
            if (oc_q != d_ocmax) begin
              oc_d      = oc_q + 4'd1;
              layer_end = 1'b0;
            end
          end
          default: ;
        endcase
        if (!layer_end) begin
          state_d = S_ISSUE;
        end else begin
          oc_d = '0;
          ig_d = '0;
          if (d_op == OP_RES || d_last) begin
            state_d = S_DONE;
            stop_d  = 1'b1;
          end else if (layer_q == LW'(NUM_LAYERS - 1)) begin
            // Ran off the end of the table without a terminating layer.
            err_d   = 1'b1;
            state_d = S_DONE;
            stop_d  = 1'b1;
          end else begin
            layer_d = layer_q + LW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign pass_valid = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign eng_start  = (state_q == S_ISSUE);
  assign busy       = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                      (state_q == S_WAIT)  || (state_q == S_ADV);
  assign STOP       = stop_q;
  assign err        = err_q;
  assign RESULT     = stop_q ? result_q : 4'hF;

  // Pass address generation; all sums wrap at the port width.
  always_comb begin
    eng_op      = '0;
    memstartp   = '0;
    memstartw   = '0;
    memstartzap = '0;
    matrix      = '0;
    bias        = 1'b0;
    globmaxp_en = 1'b0;
    if (pass_valid) begin
      eng_op      = d_op;
      matrix      = d_mat;
      memstartp   = PW'(d_src);
      memstartw   = WW'(d_wbase);
      memstartzap = PW'(d_dst);
      case (d_op)
        OP_CONV: begin
          memstartp   = PW'(d_src) + PW'(ig_q) * PW'(m2) * PW'(4);
          memstartw   = WW'(d_wbase) + WW'(oc_q) * (WW'(d_igmax) + WW'(1)) + WW'(ig_q);
          // Global max-pool output is one value per channel.
          memstartzap = PW'(d_dst) + (d_gmp ? PW'(oc_q) : PW'(oc_q) * PW'(m2));
          bias        = (ig_q == d_igmax);
          globmaxp_en = d_gmp & (ig_q == d_igmax);
        end
        OP_MAXP: begin
          memstartp   = PW'(d_src) + PW'(oc_q) * PW'(m2);
          memstartzap = PW'(d_dst) + PW'(oc_q) * PW'(m2 >> 2);
        end
        default: ;
      endcase
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] wait_cnt_q, perf_cycles_q, perf_total_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      perf_cycles_q <= '0;
      perf_total_q  <= '0;
    end else if (state_q == S_IDLE && GO) begin
      wait_cnt_q    <= '0;
      perf_cycles_q <= '0;
      perf_total_q  <= '0;
    end else begin
      if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + 32'd1;
      if (state_q == S_ADV && layer_end) begin
        perf_cycles_q <= wait_cnt_q;
        wait_cnt_q    <= '0;
      end
      if (busy && perf_total_q != '1) perf_total_q <= perf_total_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_total  = perf_total_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;
  logic        clk, rst, GO, desc_we, eng_done;
  logic [3:0]  desc_addr, res_in;
  logic [55:0] desc_data;
  logic [1:0]  eng_op;
  logic        eng_start, bias, globmaxp_en, STOP, busy, err;
  logic [12:0] memstartp, memstartw, memstartzap;
  logic [4:0]  matrix;
  logic [3:0]  RESULT;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_total;
`endif

  layer_sequencer dut (
    .clk(clk), .rst(rst), .GO(GO), .desc_we(desc_we), .desc_addr(desc_addr),
    .desc_data(desc_data), .eng_op(eng_op), .eng_start(eng_start),
    .eng_done(eng_done), .memstartp(memstartp), .memstartw(memstartw),
    .memstartzap(memstartzap), .matrix(matrix), .bias(bias),
    .globmaxp_en(globmaxp_en), .res_in(res_in), .RESULT(RESULT),
    .STOP(STOP), .busy(busy), .err(err)
`ifdef LAYER_SEQ_PERF_EN
    , .perf_cycles(perf_cycles), .perf_total(perf_total)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Bench copy of the descriptor table and pass scoreboard.
  // Pass word: {op[47:46], p[45:33], w[32:20], zap[19:7], mat[6:2], bias[1], gmp_en[0]}
  logic [55:0] tbl [16];
  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];
  bit          exp_err, exp_res_valid;
  logic [3:0]  last_res;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] mk(input int op, input int last, input int gmp,
                                     input int mat, input int igm, input int ocm,
                                     input int src, input int dst, input int wb);
    mk = {op[1:0], last[0], gmp[0], mat[4:0], igm[3:0], ocm[3:0],
          src[12:0], dst[12:0], wb[12:0]};
  endfunction

  function automatic logic [47:0] pk(input int op, input int p, input int w, input int z,
                                     input int mat, input int b, input int g);
    pk = {op[1:0], p[12:0], w[12:0], z[12:0], mat[4:0], b[0], g[0]};
  endfunction

  // Reference model: expand the table into the ordered list of passes.
  task automatic build_model();
    int op, last, gmp, mat, igm, ocm, src, dst, wb, m2;
    bit fin;
    exp_q.delete();
    exp_err = 0;
    exp_res_valid = 0;
    fin = 0;
    for (int l = 0; l < 16 && !fin; l++) begin
      op = tbl[l][55:54]; last = tbl[l][53]; gmp = tbl[l][52];
      mat = tbl[l][51:47]; igm = tbl[l][46:43]; ocm = tbl[l][42:39];
      src = tbl[l][38:26]; dst = tbl[l][25:13]; wb = tbl[l][12:0];
      m2 = mat * mat;
      case (op)
        0: for (int oc = 0; oc <= ocm; oc++)
             for (int ig = 0; ig <= igm; ig++)
               exp_q.push_back(pk(0, (src + ig * 4 * m2) % 8192,
                                  (wb + oc * (igm + 1) + ig) % 8192,
                                  gmp ? (dst + oc) % 8192 : (dst + oc * m2) % 8192,
                                  mat, (ig == igm), gmp && (ig == igm)));
        1: for (int oc = 0; oc <= ocm; oc++)
             exp_q.push_back(pk(1, (src + oc * m2) % 8192, wb,
                                (dst + oc * (m2 / 4)) % 8192, mat, 0, 0));
        2: exp_q.push_back(pk(2, src, wb, dst, mat, 0, 0));
        default: begin
          exp_q.push_back(pk(3, src, wb, dst, mat, 0, 0));
          exp_res_valid = 1;
          fin = 1;
        end
      endcase
      if (!fin && last == 1) fin = 1;
      if (!fin && l == 15) exp_err = 1;
    end
  endtask

  // driver tasks
  task automatic wr(input int a, input logic [55:0] d);
    @(negedge clk);
    desc_we = 1'b1; desc_addr = a[3:0]; desc_data = d;
    @(negedge clk);
    desc_we = 1'b0;
    tbl[a] = d;
  endtask

  // Runs one GO..STOP sequence, answering every eng_start as the engine would.
  task automatic run(input bit poke, input bit go_in_done, input int fix_d,
                     input int fix_r, output int lat);
    int cyc, d, n_exp, npass;
    logic [47:0] e, o;
    logic [3:0]  r;
    logic [63:0] junk;
    obs_q.delete();
    lat = -1; npass = 0; last_res = 4'hF;
    n_exp = exp_q.size();
    @(negedge clk); GO = 1'b1; cyc = 1;
    @(negedge clk); GO = 1'b0; cyc = 2;
    while (STOP !== 1'b1 && cyc < 3000) begin
      if (eng_start === 1'b1) begin
        if (lat < 0) lat = cyc;
        o = {eng_op, memstartp, memstartw, memstartzap, matrix, bias, globmaxp_en};
        obs_q.push_back(o);
        npass++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hxxxx_xxxx_xxxx;
        chk("pass", o, e);
        if (poke) begin
          junk = {$urandom, $urandom};
          desc_we = 1'b1; desc_addr = 4'd0; desc_data = junk[55:0];
          poke = 0;
        end
        d = (fix_d > 0) ? fix_d : $urandom_range(1, 5);
        repeat (d) begin @(negedge clk); desc_we = 1'b0; cyc++; end
        chk("hold", {eng_op, memstartp, memstartw, memstartzap, matrix, bias, globmaxp_en}, e);
        r = (fix_r >= 0) ? fix_r[3:0] : 4'($urandom_range(0, 9));
        if (e[47:46] == 2'd3) last_res = r;
        eng_done = 1'b1; res_in = r;
        @(negedge clk); eng_done = 1'b0; cyc++;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    chk("stop", STOP, 1);
    chk("busy_done", busy, 0);
    chk("err", err, exp_err);
    chk("result", RESULT, exp_res_valid ? last_res : 4'hF);
    chk("npass", npass, n_exp);
    if (go_in_done) begin
      GO = 1'b1;
      @(negedge clk); GO = 1'b0;
      chk("go_in_done_busy", busy, 0);
      chk("go_in_done_stop", STOP, 1);
    end
  endtask

  int lat, starts, k, nl, op;

  initial begin
    rst = 1'b1; GO = 0; desc_we = 0; desc_addr = 0; desc_data = 0;
    eng_done = 0; res_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_start", eng_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stop", STOP, 0);
    chk("rst_err", err, 0);
    chk("rst_result", RESULT, 4'hF);
    chk("rst_addr", {memstartp, memstartw, memstartzap}, 0);
    chk("rst_misc", {eng_op, matrix, bias, globmaxp_en}, 0);
    rst = 1'b0;

    // single result descriptor
    wr(0, mk(3, 1, 0, 0, 0, 0, 0, 0, 0));
    build_model();
    run(0, 0, 5, 7, lat);
    chk("t1_lat", lat, 3);
    chk("t1_result", RESULT, 7);

    // conv 28x28, four output channels; a table write during the run is ignored
    wr(0, mk(0, 1, 0, 28, 0, 3, 0, 784, 0));
    build_model();
    run(1, 0, 0, -1, lat);
    for (int i = 0; i < 4; i++) begin
      chk("t2_zap", 48'(obs_q[i][19:7]), 48'(784 * (i + 1)));
      chk("t2_w", 48'(obs_q[i][32:20]), 48'(i));
      chk("t2_bias", 48'(obs_q[i][1]), 1);
    end
    build_model();
    run(0, 0, 0, -1, lat);

    // conv 14x14, two input groups, two channels; GO during DONE
    wr(0, mk(0, 1, 0, 14, 1, 1, 100, 2000, 50));
    build_model();
    run(0, 1, 0, -1, lat);
    for (int i = 0; i < 4; i++) begin
      chk("t3_p", 48'(obs_q[i][45:33]), (i % 2) ? 884 : 100);
      chk("t3_bias", 48'(obs_q[i][1]), 48'(i % 2));
    end

    // maxp 28x28
    wr(0, mk(1, 1, 0, 28, 0, 3, 300, 3920, 0));
    build_model();
    run(0, 0, 0, -1, lat);
    chk("t4_zap0", 48'(obs_q[0][19:7]), 3920);
    chk("t4_zap3", 48'(obs_q[3][19:7]), 4508);

    // 16 conv layers with no terminator: overrun
    for (int l = 0; l < 16; l++)
      wr(l, mk(0, 0, $urandom_range(0, 1), $urandom_range(1, 31), 0, 0,
               $urandom_range(0, 8191), $urandom_range(0, 8191), $urandom_range(0, 8191)));
    build_model();
    run(0, 0, 1, -1, lat);
    chk("t5_err", err, 1);
    chk("t5_result", RESULT, 4'hF);

    // randomized layer tables
    for (int t = 0; t < 8; t++) begin
      nl = $urandom_range(1, 5);
      for (int l = 0; l < nl; l++) begin
        op = (l == nl - 1 && $urandom_range(0, 1)) ? 3 : $urandom_range(0, 2);
        wr(l, mk(op, (l == nl - 1), $urandom_range(0, 1), $urandom_range(1, 31),
                 $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 8191),
                 $urandom_range(0, 8191), $urandom_range(0, 8191)));
      end
      build_model();
      run(0, 0, 0, -1, lat);
      chk("rnd_lat", lat, 3);
    end

    // reset in WAIT, then a stray eng_done and a table write
    wr(0, mk(0, 1, 0, 5, 0, 3, 10, 20, 30));
    @(negedge clk); GO = 1'b1;
    @(negedge clk); GO = 1'b0;
    k = 0;
    while (eng_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("t6_start", eng_start, 1);
    @(negedge clk);
    chk("t6_busy_wait", busy, 1);
    rst = 1'b1;
    #2;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_outs", {eng_op, memstartp, memstartw, memstartzap, matrix, bias, globmaxp_en}, 0);
    chk("t6_rst_flags", {STOP, err, RESULT}, 6'b00_1111);
    @(negedge clk); rst = 1'b0;
    eng_done = 1'b1; desc_we = 1'b1; desc_addr = 4'd0;
    desc_data = mk(3, 1, 0, 0, 0, 0, 1, 2, 3);
    tbl[0] = desc_data;
    starts = 0;
    repeat (6) begin
      @(negedge clk); eng_done = 1'b0; desc_we = 1'b0;
      if (eng_start === 1'b1) starts++;
    end
    chk("t6_no_start", starts, 0);
    chk("t6_idle_busy", busy, 0);
    build_model();
    run(0, 0, 0, -1, lat);
    chk("t6_write_taken", 48'(obs_q.size() > 0 ? obs_q[0][47:46] : 2'd0), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
